// File: rtl/spi_multichan_receiver.sv
// Purpose: SPI slave receiver that turns MISO into NUM_CH channel words per frame (DATA_W data bits per SLOT_W-bit slot).
// Latency: a word appears on the outputs directly after the posedge that samples its last data bit.
// Backpressure: none. The outputs are strobes (ch_valid/frame_valid) and the consumer must take them in the cycle they are high.
//
// Ports:
//   reset        async active-low clear of all state and outputs
//   serial_clk   SPI clock, all sampling on posedge
//   chip_select  active-low select; high = idle, or abort when a frame is in progress
//   miso         serial data in
//   mosi         tied low (receive-only)
//   data_out     last complete frame, channel k at [k*DATA_W +: DATA_W]
//   ch_data      most recent channel word, tagged by ch_id and strobed by ch_valid
//   frame_valid  one-cycle pulse when data_out takes a new frame
//   frame_error  one-cycle pulse when chip_select rises in the middle of a frame
module spi_multichan_receiver #(
   parameter int DATA_W    = 16,
   parameter int SLOT_W    = 32,
   parameter int NUM_CH    = 2,
   parameter int MSB_FIRST = 1,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     reset,
   input  logic                     serial_clk,
   input  logic                     chip_select,
   input  logic                     miso,
   output logic                     mosi,
   output logic [NUM_CH*DATA_W-1:0] data_out,
   output logic [DATA_W-1:0]        ch_data,
   output logic [CH_W-1:0]          ch_id,
   output logic                     ch_valid,
   output logic                     frame_valid,
   output logic                     frame_error
);

   localparam int BIT_W   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
   localparam int SLOT_M1 = SLOT_W - 1;
   localparam int DATA_M1 = DATA_W - 1;
   localparam int CH_M1   = NUM_CH - 1;

   // Data-bit comparisons use one extra bit because DATA_W can equal SLOT_W.
   localparam logic [BIT_W:0]   DATA_LIM  = DATA_W[BIT_W:0];
   localparam logic [BIT_W:0]   DATA_LAST = DATA_M1[BIT_W:0];
   localparam logic [BIT_W-1:0] BIT_LAST  = SLOT_M1[BIT_W-1:0];
   localparam logic [CH_W-1:0]  CH_LAST   = CH_M1[CH_W-1:0];

   logic [BIT_W-1:0]         bit_cnt;
   logic [CH_W-1:0]          ch_cnt;
   logic [DATA_W-1:0]        sr;
   logic [DATA_W-1:0]        word;
   logic [NUM_CH*DATA_W-1:0] staging;
   logic [NUM_CH*DATA_W-1:0] frame_word;
   logic                     in_data;
   logic                     last_data;
   logic                     last_bit;
   logic                     last_ch;

   assign mosi = 1'b0;

   assign in_data   = ({1'b0, bit_cnt} < DATA_LIM);
   assign last_data = ({1'b0, bit_cnt} == DATA_LAST);
   assign last_bit  = (bit_cnt == BIT_LAST);
   assign last_ch   = (ch_cnt == CH_LAST);

   // Shift result that includes the miso bit sampled on this edge. The capture logic uses this
   // value directly, so the completed word is visible one edge earlier than it would be from sr.
   assign word = (MSB_FIRST != 0) ? {sr[DATA_W-2:0], miso} : {miso, sr[DATA_W-1:1]};

   // The final channel bypasses staging, so data_out takes the whole frame in one update.
   always_comb begin
      frame_word = staging;
      frame_word[(NUM_CH-1)*DATA_W +: DATA_W] = word;
   end

   always_ff @(posedge serial_clk or negedge reset) begin
      if (!reset) begin
         bit_cnt     <= '0;
         ch_cnt      <= '0;
         sr          <= '0;
         staging     <= '0;
         data_out    <= '0;
         ch_data     <= '0;
         ch_id       <= '0;
         ch_valid    <= 1'b0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         ch_valid    <= 1'b0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         if (chip_select) begin
            bit_cnt     <= '0;
            ch_cnt      <= '0;
            sr          <= '0;
            staging     <= '0;
            // Nonzero counters mean a frame was in progress. After the first CS-high edge the
            // counters are zero, so a long idle produces only one pulse.
            frame_error <= (bit_cnt != '0) || (ch_cnt != '0);
         end else begin
            if (in_data) begin
               sr <= word;
            end
            if (last_data) begin
               ch_data  <= word;
               ch_id    <= ch_cnt;
               ch_valid <= 1'b1;
               staging[ch_cnt*DATA_W +: DATA_W] <= word;
               if (last_ch) begin
                  data_out    <= frame_word;
                  frame_valid <= 1'b1;
               end
            end
            // When the last slot of a frame ends, both counters return to zero and the next
            // frame starts on the following edge.
            if (last_bit) begin
               bit_cnt <= '0;
               ch_cnt  <= last_ch ? '0 : ch_cnt + 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

endmodule
